fma_seq: RTL and testbench

Sequencer for the single-precision fused multiply-add path. Accepts an operand triple (a, b, c) for z = a*b + c, time-multiplexes one shared `unpack` instance across the three operands, and issues the captured exponent/fraction/sign fields to the FMA core. It returns the core result, or a bypass result for NaN inputs, through stb/ack handshakes. It sits between the operand source and the `unpack`/FMA core pair.

---
 rtl/fma_pkg.sv | 33 +++
 rtl/fma_seq.sv | 188 ++++++++++++++++++
 tb/tb_fma_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fma_pkg
// Description : Shared widths, sequencer state encoding, operand slot type
//               and quiet-NaN constant for the FMA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

  localparam int FP    = 32;
  localparam int FPexp = 8;
  localparam int FPfra = 23;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UNPK  = 3'd1,
    CHECK = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [FPexp:0] e;
    logic [FPfra:0] f;
    logic           nan;
    logic           inf;
  } slot_t;

  localparam logic [FP-1:0] QNAN = {1'b0, {FPexp{1'b1}}, 1'b1, {(FPfra-1){1'b0}}};

endpackage : fma_pkg
`default_nettype wire

// File: rtl/fma_seq.sv
`default_nettype none
// ============================================================================
// Module      : fma_seq
// Description : Sequences three operands through one shared unpack unit,
//               issues the fields to the FMA core and returns the result.
//               Optional NaN bypass is compiled in with FMA_NAN_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fma_seq
  import fma_pkg::*;
#(
  parameter int FP    = fma_pkg::FP,
  parameter int FPexp = fma_pkg::FPexp,
  parameter int FPfra = fma_pkg::FPfra
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FP-1:0]    in_a,
  input  logic [FP-1:0]    in_b,
  input  logic [FP-1:0]    in_c,
  input  logic             in_stb,
  output logic             in_ack,
  output logic [FP-1:0]    up_a,
  output logic             up_stb,
  input  logic             up_ack,
  input  logic [FPexp:0]   up_e,
  input  logic [FPfra:0]   up_f,
  input  logic             up_nan,
  input  logic             up_inf,
  output logic [2:0]       core_s,
  output logic [FPexp:0]   core_a_e,
  output logic [FPexp:0]   core_b_e,
  output logic [FPexp:0]   core_c_e,
  output logic [FPfra:0]   core_a_f,
  output logic [FPfra:0]   core_b_f,
  output logic [FPfra:0]   core_c_f,
  output logic             core_stb,
  input  logic             core_ack,
  input  logic [FP-1:0]    core_z,
  input  logic             core_z_stb,
  output logic             core_z_ack,
  output logic [FP-1:0]    out_z,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             busy
);

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [FP-1:0]   opnd_q [0:2];
  slot_t           slot_q [0:2];
  logic [2:0]      core_s_q;
  logic [FP-1:0]   up_a_q;
  logic [FP-1:0]   out_z_q;
  logic            in_ack_q;
  logic            up_stb_q;
  logic            core_stb_q;
  logic            core_z_ack_q;
  logic            out_stb_q;
  logic            busy_q;
  logic            w_unused_flags;

`ifdef FMA_NAN_BYPASS_EN
  logic w_any_nan;
  assign w_any_nan      = slot_q[0].nan | slot_q[1].nan | slot_q[2].nan;
  // Infinities always go to the core, so their flags are captured but not consumed.
  assign w_unused_flags = ^{slot_q[0].inf, slot_q[1].inf, slot_q[2].inf};
`else
  assign w_unused_flags = ^{slot_q[0].inf, slot_q[1].inf, slot_q[2].inf,
                            slot_q[0].nan, slot_q[1].nan, slot_q[2].nan};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        opnd_q[i] <= '0;
        slot_q[i] <= '0;
      end
      core_s_q     <= '0;
      up_a_q       <= '0;
      out_z_q      <= '0;
      in_ack_q     <= 1'b0;
      up_stb_q     <= 1'b0;
      core_stb_q   <= 1'b0;
      core_z_ack_q <= 1'b0;
      out_stb_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_stb && in_ack_q) begin
            opnd_q[0] <= in_a;
            opnd_q[1] <= in_b;
            opnd_q[2] <= in_c;
            core_s_q  <= {in_c[FP-1], in_b[FP-1], in_a[FP-1]};
            up_a_q    <= in_a;
            up_stb_q  <= 1'b1;
            idx_q     <= 2'd0;
            in_ack_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= UNPK;
          end else begin
            in_ack_q <= 1'b1;
          end
        end
        UNPK: begin
          if (up_stb_q && up_ack) begin
            slot_q[idx_q] <= '{e: up_e, f: up_f, nan: up_nan, inf: up_inf};
            // Present the next operand immediately so the unpacker sees no bubble.
            case (idx_q)
              2'd0: begin
                up_a_q <= opnd_q[1];
                idx_q  <= 2'd1;
              end
              2'd1: begin
                up_a_q <= opnd_q[2];
                idx_q  <= 2'd2;
              end
              default: begin
                up_stb_q <= 1'b0;
                idx_q    <= 2'd0;
                state_q  <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
`ifdef FMA_NAN_BYPASS_EN
          if (w_any_nan) begin
            out_z_q   <= QNAN;
            out_stb_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            core_stb_q <= 1'b1;
            state_q    <= ISSUE;
          end
`else
          core_stb_q <= 1'b1;
          state_q    <= ISSUE;
`endif
        end
        ISSUE: begin
          if (core_ack) begin
            core_stb_q   <= 1'b0;
            core_z_ack_q <= 1'b1;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (core_z_stb) begin
            out_z_q      <= core_z;
            core_z_ack_q <= 1'b0;
            out_stb_q    <= 1'b1;
            state_q      <= OUT;
          end
        end
        OUT: begin
          if (out_ack) begin
            out_stb_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ack     = in_ack_q;
  assign up_a       = up_a_q;
  assign up_stb     = up_stb_q;
  assign core_s     = core_s_q;
  assign core_a_e   = slot_q[0].e;
  assign core_b_e   = slot_q[1].e;
  assign core_c_e   = slot_q[2].e;
  assign core_a_f   = slot_q[0].f;
  assign core_b_f   = slot_q[1].f;
  assign core_c_f   = slot_q[2].f;
  assign core_stb   = core_stb_q;
  assign core_z_ack = core_z_ack_q;
  assign out_z      = out_z_q;
  assign out_stb    = out_stb_q;
  assign busy       = busy_q;

endmodule : fma_seq
`default_nettype wire

// File: tb/tb_fma_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fma_seq
// Description : Directed self-checking bench for fma_seq with behavioural
//               unpack and core partners. Honours FMA_NAN_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_a, in_b, in_c;
  logic        in_stb, in_ack;
  logic [31:0] up_a;
  logic        up_stb, up_ack;
  logic [8:0]  up_e;
  logic [23:0] up_f;
  logic        up_nan, up_inf;
  logic [2:0]  core_s;
  logic [8:0]  core_a_e, core_b_e, core_c_e;
  logic [23:0] core_a_f, core_b_f, core_c_f;
  logic        core_stb, core_ack;
  logic [31:0] core_z;
  logic        core_z_stb, core_z_ack;
  logic [31:0] out_z;
  logic        out_stb, out_ack;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  fma_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_stb(in_stb), .in_ack(in_ack),
    .up_a(up_a), .up_stb(up_stb), .up_ack(up_ack),
    .up_e(up_e), .up_f(up_f), .up_nan(up_nan), .up_inf(up_inf),
    .core_s(core_s),
    .core_a_e(core_a_e), .core_b_e(core_b_e), .core_c_e(core_c_e),
    .core_a_f(core_a_f), .core_b_f(core_b_f), .core_c_f(core_c_f),
    .core_stb(core_stb), .core_ack(core_ack),
    .core_z(core_z), .core_z_stb(core_z_stb), .core_z_ack(core_z_ack),
    .out_z(out_z), .out_stb(out_stb), .out_ack(out_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unpacker: unbiased exponent and fraction with hidden bit.
  function automatic logic [8:0] m_e(input logic [31:0] x);
    return {1'b0, x[30:23]} - 9'd127;
  endfunction
  function automatic logic [23:0] m_f(input logic [31:0] x);
    return {|x[30:23], x[22:0]};
  endfunction

  assign up_e   = m_e(up_a);
  assign up_f   = m_f(up_a);
  assign up_nan = (&up_a[30:23]) & (|up_a[22:0]);
  assign up_inf = (&up_a[30:23]) & ~(|up_a[22:0]);

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_core(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    check_val({tag, "/core_s"},   core_s,   {c[31], b[31], a[31]});
    check_val({tag, "/core_a_e"}, core_a_e, m_e(a));
    check_val({tag, "/core_b_e"}, core_b_e, m_e(b));
    check_val({tag, "/core_c_e"}, core_c_e, m_e(c));
    check_val({tag, "/core_a_f"}, core_a_f, m_f(a));
    check_val({tag, "/core_b_f"}, core_b_f, m_f(b));
    check_val({tag, "/core_c_f"}, core_c_f, m_f(c));
  endtask

  task automatic chk_outputs_zero(input string tag);
    check_val({tag, "/in_ack"},     in_ack,     0);
    check_val({tag, "/busy"},       busy,       0);
    check_val({tag, "/up_stb"},     up_stb,     0);
    check_val({tag, "/up_a"},       up_a,       0);
    check_val({tag, "/core_stb"},   core_stb,   0);
    check_val({tag, "/core_z_ack"}, core_z_ack, 0);
    check_val({tag, "/out_stb"},    out_stb,    0);
    check_val({tag, "/out_z"},      out_z,      0);
    check_val({tag, "/core_s"},     core_s,     0);
    check_val({tag, "/core_a_e"},   core_a_e,   0);
  endtask

  task automatic wait_in_ack(input string tag);
    int guard;
    guard = 0;
    while (in_ack !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check_val({tag, "/in_ack_wait"}, in_ack, 1);
  endtask

  // One full operation; stall counts are injected on each partner interface.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] zres,
                        input int up_st, input int core_st, input int z_lat, input int out_st,
                        input bit byp, input bit hold_in, input int exp_lat);
    logic [31:0] op [3];
    int t0;
    op[0] = a; op[1] = b; op[2] = c;
    up_ack = 0; core_ack = 0; core_z_stb = 0; out_ack = 0;
    wait_in_ack(tag);
    in_a = a; in_b = b; in_c = c; in_stb = 1;
    tick();
    t0 = cyc;
    if (hold_in) begin
      in_a = ~a; in_b = ~b; in_c = ~c;
    end else begin
      in_stb = 0;
    end
    check_val({tag, "/busy"}, busy, 1);
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < up_st; s++) begin
        up_ack = 0;
        check_val({tag, "/up_stb_stall"}, up_stb, 1);
        check_val({tag, "/up_a_stall"}, up_a, op[k]);
        tick();
      end
      up_ack = 1;
      check_val({tag, "/up_stb"}, up_stb, 1);
      check_val({tag, "/up_a"}, up_a, op[k]);
      check_val({tag, "/in_ack_busy"}, in_ack, 0);
      tick();
    end
    up_ack = 0;
    check_val({tag, "/up_stb_done"}, up_stb, 0);
    tick();
    if (byp) begin
      check_val({tag, "/core_stb_byp"}, core_stb, 0);
    end else begin
      for (int s = 0; s < core_st; s++) begin
        check_val({tag, "/core_stb_stall"}, core_stb, 1);
        chk_core({tag, "/stall"}, a, b, c);
        tick();
      end
      check_val({tag, "/core_stb"}, core_stb, 1);
      chk_core(tag, a, b, c);
      core_ack = 1;
      tick();
      core_ack = 0;
      check_val({tag, "/core_stb_off"}, core_stb, 0);
      for (int s = 0; s < z_lat; s++) begin
        check_val({tag, "/core_z_ack_wait"}, core_z_ack, 1);
        tick();
      end
      check_val({tag, "/core_z_ack"}, core_z_ack, 1);
      core_z = zres; core_z_stb = 1;
      tick();
      core_z_stb = 0; core_z = 32'hDEAD_BEEF;
      check_val({tag, "/core_z_ack_off"}, core_z_ack, 0);
    end
    in_stb = 0;
    for (int s = 0; s < out_st; s++) begin
      check_val({tag, "/out_stb_stall"}, out_stb, 1);
      check_val({tag, "/out_z_stall"}, out_z, zres);
      tick();
    end
    check_val({tag, "/out_stb"}, out_stb, 1);
    check_val({tag, "/out_z"}, out_z, zres);
    out_ack = 1;
    tick();
    out_ack = 0;
    check_val({tag, "/latency"}, cyc - t0, exp_lat);
    check_val({tag, "/out_stb_off"}, out_stb, 0);
    check_val({tag, "/busy_off"}, busy, 0);
    check_val({tag, "/in_ack_late"}, in_ack, 0);
    tick();
    check_val({tag, "/in_ack_back"}, in_ack, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_stb = 0; in_a = 0; in_b = 0; in_c = 0;
    up_ack = 0; core_ack = 0; core_z = 0; core_z_stb = 0; out_ack = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1;
    check_val("reset/in_ack_rel", in_ack, 0);
    tick();
    check_val("reset/in_ack_rise", in_ack, 1);

    // 1*2+0.5 = 2.5 ; -1*2+0.5 = -1.5
    run_op("basic", 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40200000,
           0, 0, 0, 0, 0, 0, 7);
    run_op("sign", 32'hBF800000, 32'h40000000, 32'h3F000000, 32'hBFC00000,
           0, 0, 0, 0, 0, 0, 7);
`ifdef FMA_NAN_BYPASS_EN
    run_op("nan", 32'h3F800000, 32'h7FC00001, 32'h3F000000, 32'h7FC00000,
           0, 0, 0, 0, 1, 0, 5);
    run_op("nan_bp", 32'h3F800000, 32'h7FC00001, 32'h3F000000, 32'h7FC00000,
           1, 0, 0, 2, 1, 0, 10);
`else
    run_op("nan", 32'h3F800000, 32'h7FC00001, 32'h3F000000, 32'h7FC00001,
           0, 0, 0, 0, 0, 0, 7);
`endif
    run_op("inf", 32'h3F800000, 32'h7F800000, 32'h3F000000, 32'h7F800000,
           0, 0, 0, 0, 0, 0, 7);
    // 3 stalls per unpack (9) + core_ack 2 + core answers 2 late + out_ack 4 = 17
    run_op("bp", 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40200000,
           3, 2, 2, 4, 0, 0, 24);

    // Abandon an operation while it waits on the core.
    wait_in_ack("mid_rst");
    in_a = 32'h3F800000; in_b = 32'h40000000; in_c = 32'h3F000000; in_stb = 1;
    up_ack = 1; core_ack = 1; core_z_stb = 0; out_ack = 0;
    tick();
    in_stb = 0;
    repeat (5) tick();
    check_val("mid_rst/in_wait", core_z_ack, 1);
    #2 rst_n = 0;
    #1 chk_outputs_zero("mid_rst");
    up_ack = 0; core_ack = 0;
    @(negedge clk);
    rst_n = 1;
    check_val("mid_rst/in_ack_rel", in_ack, 0);
    tick();
    check_val("mid_rst/in_ack_rise", in_ack, 1);
    run_op("post_rst", 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40200000,
           0, 0, 0, 0, 0, 0, 7);

    run_op("hold_in", 32'hBF800000, 32'h40000000, 32'h3F000000, 32'hBFC00000,
           1, 1, 1, 1, 0, 1, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fma_seq
`default_nettype wire
